// File: rtl/multi_cycle_alu_pkg.sv
// ==== multi_cycle_alu_pkg : shared opcodes, widths and latencies -- rev 1.0 ====
`default_nettype none

package multi_cycle_alu_pkg;

   localparam int OPERAND_MAX_DATA_WIDTH = 8;

   // Latencies in rising edges, counting the acceptance edge as the first.
   localparam int LAT_SIMPLE = 2;

   function automatic int lat_iter(input int w);
      return w + 1;
   endfunction

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_MUL = 3'd5,
      OP_DIV = 3'd6,
      OP_ILL = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic logic is_iter_op(input op_e o);
      return (o == OP_MUL) || (o == OP_DIV);
   endfunction

endpackage

`default_nettype wire

// File: rtl/multi_cycle_alu_iter.sv
// ==== alu_iter_unit : one-bit-per-cycle shift-add multiplier / restoring divider -- rev 1.0 ====
`default_nettype none

module alu_iter_unit #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           is_div,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           done,
   output logic [2*W-1:0] result_next
);

   localparam int CW = $clog2(W + 1);

   logic [CW-1:0] count;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;
   logic [W-1:0]  d;
   logic          div_mode;

   logic [W:0]    mul_sum;
   logic [W:0]    div_shift;
   logic          div_ge;
   logic [W-1:0]  hi_next;
   logic [W-1:0]  lo_next;

   // hi holds the partial product (MUL) or partial remainder (DIV); lo holds
   // the multiplier being consumed (MUL) or the dividend turning into the quotient (DIV).
   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, d} : {(W+1){1'b0}});
      div_shift = {hi, lo[W-1]};
      div_ge    = (div_shift >= {1'b0, d});
      hi_next   = hi;
      lo_next   = lo;
      if (div_mode) begin
         hi_next = div_ge ? W'(div_shift - {1'b0, d}) : W'(div_shift);
         lo_next = {lo[W-2:0], div_ge};
      end else begin
         hi_next = mul_sum[W:1];
         lo_next = {mul_sum[0], lo[W-1:1]};
      end
   end

   assign done        = (count == CW'(1));
   assign result_next = {hi_next, lo_next};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         hi       <= '0;
         lo       <= '0;
         d        <= '0;
         div_mode <= 1'b0;
      end else if (start) begin
         count    <= CW'(W);
         hi       <= '0;
         lo       <= a;
         d        <= b;
         div_mode <= is_div;
      end else if (count != '0) begin
         count <= count - CW'(1);
         hi    <= hi_next;
         lo    <= lo_next;
      end
   end

endmodule

`default_nettype wire

// File: rtl/multi_cycle_alu.sv
// ==== multi_cycle_alu : handshaked ALU, single-cycle logic ops, iterative MUL/DIV -- rev 1.0 ====
`default_nettype none

module multi_cycle_alu
   import multi_cycle_alu_pkg::*;
#(
   parameter int W = OPERAND_MAX_DATA_WIDTH
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic [2:0]     op,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] result,
   output logic           err
);

   state_e       state;
   logic [W-1:0] a_r;
   logic [W-1:0] b_r;
   op_e          op_r;

   logic           accept;
   logic           iter_start;
   logic           iter_done;
   logic [2*W-1:0] iter_result;
   logic [W:0]     add_sum;
   logic [W:0]     sub_diff;
   logic [2*W-1:0] simple_result;

   assign accept     = (state == S_IDLE) && in_valid;
   // The iterative unit loads straight from the ports so its W steps line up with the W EXEC cycles.
   assign iter_start = accept && is_iter_op(op_e'(op));

   alu_iter_unit #(
      .W (W)
   ) u_iter (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (iter_start),
      .is_div      (op == OP_DIV),
      .a           (a),
      .b           (b),
      .done        (iter_done),
      .result_next (iter_result)
   );

   always_comb begin
      add_sum       = {1'b0, a_r} + {1'b0, b_r};
      sub_diff      = {1'b0, a_r} - {1'b0, b_r};
      simple_result = '0;
      case (op_r)
         OP_ADD:  simple_result = {{(W-1){1'b0}}, add_sum};
         OP_SUB:  simple_result = {{(W-1){sub_diff[W]}}, sub_diff};
         OP_AND:  simple_result = {{W{1'b0}}, a_r & b_r};
         OP_OR:   simple_result = {{W{1'b0}}, a_r | b_r};
         OP_XOR:  simple_result = {{W{1'b0}}, a_r ^ b_r};
         default: simple_result = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         err       <= 1'b0;
         a_r       <= '0;
         b_r       <= '0;
         op_r      <= OP_ADD;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_r      <= a;
                  b_r      <= b;
                  op_r     <= op_e'(op);
                  state    <= S_EXEC;
                  in_ready <= 1'b0;
               end
            end
            S_EXEC: begin
               if (is_iter_op(op_r)) begin
                  if (iter_done) begin
                     result    <= iter_result;
                     err       <= (op_r == OP_DIV) && (b_r == '0);
                     state     <= S_DONE;
                     out_valid <= 1'b1;
                  end
               end else begin
                  result    <= simple_result;
                  err       <= (op_r == OP_ILL);
                  state     <= S_DONE;
                  out_valid <= 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= S_IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_alu.sv
// ==== tb_multi_cycle_alu : directed vectors for multi_cycle_alu (W=8) -- rev 1.0 ====
`default_nettype none

module tb_multi_cycle_alu;
   import multi_cycle_alu_pkg::*;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic [2:0]     op = 3'd0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [2*W-1:0] result;
   logic           err;

   int total = 0;
   int bad   = 0;

   multi_cycle_alu #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Issues one request and returns the edge count (acceptance edge = 1) until out_valid.
   task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output logic busy_ok);
      int n = 0;
      while (!in_ready && n < 40) begin
         @(posedge clk); #1; n++;
      end
      in_valid = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      busy_ok = 1'b1;
      while (!out_valid && lat < 40) begin
         if (in_ready) busy_ok = 1'b0;
         @(posedge clk); #1; lat++;
      end
      if (in_ready) busy_ok = 1'b0;
   endtask

   task automatic run_vec(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [15:0] exp_res,
                          input logic exp_err, input int exp_lat);
      int lat;
      logic busy_ok;
      send(o, x, y, lat, busy_ok);
      check({tag, "_res"}, 32'(result), 32'(exp_res));
      check({tag, "_err"}, 32'(err), 32'(exp_err));
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_busy"}, 32'(busy_ok), 32'd1);
      @(posedge clk); #1;
      check({tag, "_rdy_after"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int lat;
      logic busy_ok;

      #12;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_vec("add_carry", 3'd0, 8'd255, 8'd1,    16'h0100, 1'b0, 2);
      run_vec("sub_neg",   3'd1, 8'd5,   8'd7,    16'hFFFE, 1'b0, 2);
      run_vec("sub_pos",   3'd1, 8'd10,  8'd3,    16'h0007, 1'b0, 2);
      run_vec("and",       3'd2, 8'hF0,  8'h3C,   16'h0030, 1'b0, 2);
      run_vec("or",        3'd3, 8'hF0,  8'h0F,   16'h00FF, 1'b0, 2);
      run_vec("xor",       3'd4, 8'hAA,  8'hFF,   16'h0055, 1'b0, 2);
      run_vec("mul",       3'd5, 8'd200, 8'd250,  16'hC350, 1'b0, 9);
      run_vec("mul_max",   3'd5, 8'd255, 8'd255,  16'hFE01, 1'b0, 9);
      run_vec("mul_zero",  3'd5, 8'd0,   8'd123,  16'h0000, 1'b0, 9);
      run_vec("div",       3'd6, 8'd200, 8'd7,    16'h041C, 1'b0, 9);
      run_vec("div_eq",    3'd6, 8'd255, 8'd255,  16'h0001, 1'b0, 9);
      run_vec("div_small", 3'd6, 8'd3,   8'd10,   16'h0300, 1'b0, 9);
      run_vec("div_zero",  3'd6, 8'd37,  8'd0,    16'h25FF, 1'b1, 9);
      run_vec("illegal",   3'd7, 8'd9,   8'd9,    16'h0000, 1'b1, 2);

      // Back-pressure: result held for 5 cycles, a pending request waits for the handshake.
      out_ready = 1'b0;
      send(3'd0, 8'd20, 8'd22, lat, busy_ok);
      check("hold_lat", 32'(lat), 32'd2);
      in_valid = 1'b1; op = 3'd0; a = 8'd1; b = 8'd1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_res", 32'(result), 32'h002A);
         check("hold_err", 32'(err), 32'd0);
         check("hold_rdy", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("hs_idle_rdy", 32'(in_ready), 32'd1);
      check("hs_idle_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("hs_accept_rdy", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check("hs_next_valid", 32'(out_valid), 32'd1);
      check("hs_next_res", 32'(result), 32'h0002);
      @(posedge clk); #1;

      // Reset in the 4th EXEC cycle of a MUL.
      in_valid = 1'b1; op = 3'd5; a = 8'd200; b = 8'd250;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_valid", 32'(out_valid), 32'd0);
      check("rst_mid_rdy", 32'(in_ready), 32'd1);
      check("rst_mid_res", 32'(result), 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_no_result", 32'(out_valid), 32'd0);
      run_vec("post_rst_add", 3'd0, 8'd3, 8'd4, 16'h0007, 1'b0, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/multi_cycle_alu.md
MULTI_CYCLE_ALU -- requirements
Module: multi_cycle_alu

Interface
REQ-001 Parameter: W, default OPERAND_MAX_DATA_WIDTH (8), operand width in bits.
REQ-002 Port: clk  in  1  sole clock, all state on rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  in  1  request present on a, b, op.
REQ-005 Port: in_ready  out  1  block can accept a request.
REQ-006 Port: a  in  W  operand A, unsigned.
REQ-007 Port: b  in  W  operand B, unsigned.
REQ-008 Port: op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 DIV, 7 illegal.
REQ-009 Port: out_valid  out  1  result and err are valid.
REQ-010 Port: out_ready  in  1  consumer accepts the result.
REQ-011 Port: result  out  2W  operation result.
REQ-012 Port: err  out  1  divide-by-zero or illegal opcode.

Function
REQ-013 The FSM SHALL use states IDLE, EXEC and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with in_valid&&in_ready; a, b and op are registered at acceptance.
REQ-015 IDLE->EXEC on acceptance; EXEC->DONE when the operation completes; DONE->IDLE on a rising edge with out_valid&&out_ready.
REQ-016 out_valid SHALL be 1 exactly in DONE; result and err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-017 ADD, SUB, AND, OR, XOR and illegal opcodes SHALL take one EXEC cycle: out_valid rises 2 edges after the acceptance edge.
REQ-018 MUL and DIV SHALL take W EXEC cycles (one bit per cycle, driven by a down-counter): out_valid rises W+1 edges after the acceptance edge.
REQ-019 ADD result = zero-extended a+b, carry in bit W; SUB result = a-b sign-extended to 2W (two's complement).
REQ-020 AND/OR/XOR result = bitwise result zero-extended to 2W.
REQ-021 MUL SHALL use shift-add; result = full 2W-bit unsigned product.
REQ-022 DIV SHALL use restoring division; result[W-1:0] = quotient, result[2W-1:W] = remainder.
REQ-023 DIV with b=0 SHALL still take W EXEC cycles, produce quotient all-ones and remainder = a, and set err=1.
REQ-024 Opcode 7 SHALL produce result=0 and err=1; err=0 for all other non-faulting cases.
REQ-025 Back-to-back requests: after the DONE->IDLE edge, in_ready=1 for the next cycle, giving at most one transaction every latency+1 cycles.
REQ-026 Outside DONE, result and err SHALL keep their last values and SHALL be ignored by consumers.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, in_ready=1, out_valid=0, result=0, err=0, and clear the counter and datapath registers.
REQ-028 Reset asserted in EXEC or DONE SHALL abandon the operation with no result delivered; the first request after reset release SHALL behave normally.

Structure
REQ-029 The opcode enum, OPERAND_MAX_DATA_WIDTH and the latency constants SHALL live in the shared parameters package, also used by the bench's transaction classes.
REQ-030 The MUL/DIV iterative datapath SHALL be one sub-module, alu_iter_unit, with a start/done handshake and the iteration counter inside it; the FSM and logic ops stay in multi_cycle_alu.

Verification (W=8)
REQ-031 ADD a=255, b=1 -> result=0x0100, err=0, out_valid 2 edges after acceptance.
REQ-032 SUB a=5, b=7 -> result=0xFFFE, err=0.
REQ-033 MUL a=200, b=250 -> result=0xC350, err=0, out_valid 9 edges after acceptance; in_ready=0 throughout.
REQ-034 DIV a=200, b=7 -> result=0x041C; DIV a=37, b=0 -> result=0x25FF, err=1.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> result, err and out_valid stable, in_ready=0; the next request is accepted only after the handshake.
REQ-036 Pulse rst_n low in the 4th EXEC cycle of MUL -> out_valid=0, in_ready=1 immediately; a following ADD 3+4 returns 0x0007.
